// File: rtl/dda_state_streamer_pkg.sv
// Shared types and helpers for the DDA state streamer and its UART core.
// STREAM_CHECKSUM_EN (define) appends an XOR checksum byte to each frame.
package dda_stream_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic {
        SS_IDLE,
        SS_SEND
    } stream_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

`ifdef STREAM_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    function automatic int calc_div(int clk_freq, int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int calc_frame_bytes(int n);
        return 1 + 3 * (n / 8) + (CSUM_EN ? 1 : 0);
    endfunction

endpackage

// File: rtl/dda_state_streamer_if.sv
// Bundle between the solver side and the state streamer.
// master: drives start/x/y/z, sees tx/busy/frame_done; slave: the streamer.
interface dda_state_streamer_if #(
    parameter int N = 16
);
    logic         start;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic [N-1:0] z;
    logic         tx;
    logic         busy;
    logic         frame_done;

    modport master (
        output start, x, y, z,
        input  tx, busy, frame_done
    );

    modport slave (
        input  start, x, y, z,
        output tx, busy, frame_done
    );
endinterface

// File: rtl/dda_state_streamer_uart_tx_core.sv
// Single-byte 8N1 UART shifter with baud counter and valid/ready intake.
// Ports: clk, rst, valid, data[7:0] in; ready, tx out. tx idles high.
module uart_tx_core
    import dda_stream_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    tx_state_t     state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud == LAST);

    // Ready in the final stop-bit cycle lets the next byte start on the
    // very edge the stop bit ends, so bytes chain without a gap.
    assign ready = (state == TX_IDLE) || ((state == TX_STOP) && bit_end);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= TX_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else if (valid && ready) begin
            state   <= TX_START;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= data;
            tx      <= 1'b0;
        end else begin
            unique case (state)
                TX_IDLE: begin
                    baud <= '0;
                    tx   <= 1'b1;
                end
                TX_START: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= TX_DATA;
                        tx    <= shreg[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (bit_end) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= TX_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (bit_end) begin
                        baud  <= '0;
                        state <= TX_IDLE;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/dda_state_streamer.sv
// Snapshots DDA state {x,y,z} and streams SYNC_BYTE, x, y, z (MSB byte
// first) as back-to-back 8N1 bytes. Ports: clk, rst, bus (slave: start,
// x, y, z in; tx, busy, frame_done out). STREAM_CHECKSUM_EN adds an XOR
// of all payload bytes after z.
module dda_state_streamer
    import dda_stream_pkg::*;
#(
    parameter int         N         = 16,
    parameter int         CLK_FREQ  = 12000000,
    parameter int         BAUD_RATE = 9600,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    dda_state_streamer_if.slave bus
);
    localparam int DIV         = calc_div(CLK_FREQ, BAUD_RATE);
    localparam int FRAME_BYTES = calc_frame_bytes(N);
    localparam int IW          = $clog2(FRAME_BYTES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES);

    stream_state_t  state;
    logic [3*N-1:0] snap;
    logic [IW-1:0]  idx;
    logic           busy_q;
    logic           done_q;

    logic           core_valid;
    logic           core_ready;
    logic [7:0]     core_data;
    logic [7:0]     next_byte;
    logic [IW-1:0]  sel;
    logic [3*N-1:0] shifted;

    // idx names the next byte to hand to the core; byte 0 (sync) is
    // handed over directly on the accepting edge.
    always_comb begin
        sel       = idx - 1'b1;
        shifted   = snap << {sel, 3'b000};
        next_byte = shifted[3*N-1 -: 8];
`ifdef STREAM_CHECKSUM_EN
        if (idx == IW'(FRAME_BYTES - 1)) begin
            next_byte = xor_bytes(snap);
        end
`endif
    end

`ifdef STREAM_CHECKSUM_EN
    function automatic logic [7:0] xor_bytes(logic [3*N-1:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 3 * N / 8; i++) begin
            acc = acc ^ v[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    always_comb begin
        core_valid = 1'b0;
        core_data  = SYNC_BYTE;
        if (state == SS_IDLE) begin
            core_valid = bus.start;
        end else if (idx != LAST_IDX) begin
            core_valid = 1'b1;
            core_data  = next_byte;
        end
    end

    // While sending, the core is only ready in the last stop-bit cycle,
    // so each ready marks the end of one byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SS_IDLE;
            snap   <= '0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                SS_IDLE: begin
                    if (bus.start) begin
                        state  <= SS_SEND;
                        snap   <= {bus.x, bus.y, bus.z};
                        idx    <= IW'(1);
                        busy_q <= 1'b1;
                    end
                end
                SS_SEND: begin
                    if (core_ready) begin
                        if (idx == LAST_IDX) begin
                            state  <= SS_IDLE;
                            idx    <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= SS_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;

    uart_tx_core #(
        .DIV(DIV)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .valid(core_valid),
        .data (core_data),
        .ready(core_ready),
        .tx   (bus.tx)
    );
endmodule

// File: tb/tb_dda_state_streamer.sv
// Self-checking bench for dda_state_streamer (DIV=4, N=16).
// Decodes the tx line and compares against a byte-level frame model.
module tb_dda_state_streamer;
    localparam int N     = 16;
    localparam int CLK_F = 1000000;
    localparam int BAUD  = 250000;
    localparam int DIV   = CLK_F / BAUD;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dda_state_streamer_if #(.N(N)) bus ();

    dda_state_streamer #(
        .N        (N),
        .CLK_FREQ (CLK_F),
        .BAUD_RATE(BAUD),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame as a list of bytes: sync, then x, y, z MSB byte first.
    function automatic bq_t model_bytes(input logic [N-1:0] vx,
                                        input logic [N-1:0] vy,
                                        input logic [N-1:0] vz);
        bq_t q;
        logic [3*N-1:0] w;
        w = {vx, vy, vz};
        q = {};
        q.push_back(8'hA5);
        for (int i = 3 * N / 8 - 1; i >= 0; i--) q.push_back(w[8*i +: 8]);
`ifdef STREAM_CHECKSUM_EN
        begin
            logic [7:0] ck;
            ck = 8'h00;
            for (int i = 1; i < q.size(); i++) ck = ck ^ q[i];
            q.push_back(ck);
        end
`endif
        return q;
    endfunction

    task automatic launch(input logic [N-1:0] vx, input logic [N-1:0] vy,
                          input logic [N-1:0] vz, input bit hold,
                          input string tag);
        bus.x = vx;
        bus.y = vy;
        bus.z = vz;
        bus.start = 1'b1;
        tick();
        chk({tag, "_acc_busy"}, 32'(bus.busy), 32'd1);
        chk({tag, "_acc_tx"}, 32'(bus.tx), 32'd0);
        if (!hold) bus.start = 1'b0;
    endtask

    // Called just after the accepting edge; returns just after the
    // completion edge.
    task automatic capture(input logic [N-1:0] vx, input logic [N-1:0] vy,
                           input logic [N-1:0] vz, input int disturb,
                           input string tag);
        bq_t  eq;
        logic tr[$];
        int   total, bad_busy, early, glitch, framing, base;
        logic lv;
        logic [7:0] got;
        eq = model_bytes(vx, vy, vz);
        total = eq.size() * 10 * DIV;
        bad_busy = 0;
        early = 0;
        glitch = 0;
        framing = 0;
        tr = {};
        for (int k = 0; k < total; k++) begin
            if (k > 0) tick();
            tr.push_back(bus.tx);
            if (bus.busy !== 1'b1) bad_busy++;
            if (bus.frame_done !== 1'b0) early++;
            if (disturb >= 0 && k == disturb) begin
                bus.x = 16'($urandom);
                bus.y = 16'($urandom);
                bus.z = 16'($urandom);
                bus.start = 1'b1;
            end else if (disturb >= 0 && k == disturb + 1) begin
                bus.start = 1'b0;
            end
        end
        tick();
        chk({tag, "_done_pulse"}, 32'(bus.frame_done), 32'd1);
        chk({tag, "_done_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done_tx"}, 32'(bus.tx), 32'd1);
        for (int b = 0; b < eq.size(); b++) begin
            got = 8'h00;
            for (int j = 0; j < 10; j++) begin
                base = (b * 10 + j) * DIV;
                lv = tr[base + DIV / 2];
                for (int c = 0; c < DIV; c++) if (tr[base + c] !== lv) glitch++;
                if (j == 0 && lv !== 1'b0) framing++;
                if (j == 9 && lv !== 1'b1) framing++;
                if (j >= 1 && j <= 8) got[j-1] = lv;
            end
            chk($sformatf("%s_byte%0d", tag, b), 32'(got), 32'(eq[b]));
        end
        chk({tag, "_bit_len"}, 32'(glitch), 32'd0);
        chk({tag, "_framing"}, 32'(framing), 32'd0);
        chk({tag, "_busy_held"}, 32'(bad_busy), 32'd0);
        chk({tag, "_no_early_done"}, 32'(early), 32'd0);
    endtask

    initial begin
        logic [N-1:0] ax, ay, az, bx, by, bz;
        int bad;

        bus.start = 1'b0;
        bus.x = '0;
        bus.y = '0;
        bus.z = '0;
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_tx", 32'(bus.tx), 32'd1);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.frame_done), 32'd0);
        rst = 1'b0;

        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) bad++;
            if (bus.frame_done !== 1'b0) bad++;
        end
        chk("idle50", 32'(bad), 32'd0);

        launch(16'hC000, 16'h14CD, 16'h7240, 1'b0, "dir");
        capture(16'hC000, 16'h14CD, 16'h7240, -1, "dir");
        tick();
        chk("dir_done_one_cycle", 32'(bus.frame_done), 32'd0);

        ax = 16'($urandom);
        ay = 16'($urandom);
        az = 16'($urandom);
        launch(ax, ay, az, 1'b0, "dist");
        capture(ax, ay, az, 100, "dist");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.busy !== 1'b0 || bus.tx !== 1'b1) bad++;
        end
        chk("dist_no_second", 32'(bad), 32'd0);

        ax = 16'($urandom);
        ay = 16'($urandom);
        az = 16'($urandom);
        bx = 16'($urandom);
        by = 16'($urandom);
        bz = 16'($urandom);
        launch(ax, ay, az, 1'b1, "b2b1");
        bus.x = bx;
        bus.y = by;
        bus.z = bz;
        capture(ax, ay, az, -1, "b2b1");
        tick();
        chk("b2b_restart_busy", 32'(bus.busy), 32'd1);
        chk("b2b_restart_tx", 32'(bus.tx), 32'd0);
        chk("b2b_restart_done", 32'(bus.frame_done), 32'd0);
        bus.start = 1'b0;
        capture(bx, by, bz, -1, "b2b2");
        tick();

        ax = 16'($urandom);
        ay = 16'($urandom) & 16'hBFFF;
        az = 16'($urandom);
        launch(ax, ay, az, 1'b0, "rst");
        repeat (150) tick();
        chk("rst_pre_tx", 32'(bus.tx), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_tx", 32'(bus.tx), 32'd1);
        chk("rst_async_busy", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rst_idle_busy", 32'(bus.busy), 32'd0);
        ax = 16'($urandom);
        ay = 16'($urandom);
        az = 16'($urandom);
        launch(ax, ay, az, 1'b0, "post");
        capture(ax, ay, az, -1, "post");
        tick();

        for (int r = 0; r < 3; r++) begin
            ax = 16'($urandom);
            ay = 16'($urandom);
            az = 16'($urandom);
            launch(ax, ay, az, 1'b0, $sformatf("rnd%0d", r));
            capture(ax, ay, az, -1, $sformatf("rnd%0d", r));
            repeat (1 + $urandom_range(0, 5)) tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
